serial_mag_comparator_ctrl: RTL and testbench

- Controller that compares two WIDTH-bit unsigned operands one bit per cycle, MSB first.
- Uses a single 1-bit magnitude comparator slice (GT/EQ/LT per bit pair) as its only datapath.
- Sits between a requester (start/done handshake) and the 1-bit comparator. Trades latency for area in the combinational-circuits library.

---
 rtl/serial_mag_comparator_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_mag_comparator_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial magnitude comparator: scans two WIDTH-bit operands MSB first
// through a single 1-bit GT/LT slice and reports GT/EQ/LT with a done pulse.
module serial_mag_comparator_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             EQ,
    output logic             LT
);

    localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               found_q, found_d;
    logic               pend_gt_q, pend_gt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;
    logic               lt_q, lt_d;

    // 1-bit comparator slice on the current MSB pair
    logic bit_gt_c, bit_lt_c;
    always_comb begin
        bit_gt_c = a_sr_q[WIDTH-1] & ~b_sr_q[WIDTH-1];
        bit_lt_c = ~a_sr_q[WIDTH-1] & b_sr_q[WIDTH-1];
    end

    logic first_diff_c, res_found_c, res_gt_c;

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        cnt_d     = cnt_q;
        found_d   = found_q;
        pend_gt_d = pend_gt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;

        first_diff_c = (bit_gt_c | bit_lt_c) & ~found_q;
        res_found_c  = found_q | bit_gt_c | bit_lt_c;
        // once a difference is recorded, later pairs no longer matter
        res_gt_c     = found_q ? pend_gt_q : bit_gt_c;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sr_d    = A_in;
                    b_sr_d    = B_in;
                    cnt_d     = '0;
                    found_d   = 1'b0;
                    pend_gt_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if ((EARLY_EXIT && first_diff_c) || (cnt_q == LAST)) begin
                    gt_d    = res_found_c & res_gt_c;
                    lt_d    = res_found_c & ~res_gt_c;
                    eq_d    = ~res_found_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    if (first_diff_c) begin
                        found_d   = 1'b1;
                        pend_gt_d = bit_gt_c;
                    end
                    a_sr_d = a_sr_q << 1;
                    b_sr_d = b_sr_q << 1;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            cnt_q     <= '0;
            found_q   <= 1'b0;
            pend_gt_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            cnt_q     <= cnt_d;
            found_q   <= found_d;
            pend_gt_q <= pend_gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign GT   = gt_q;
    assign EQ   = eq_q;
    assign LT   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Directed bench for serial_mag_comparator_ctrl; one instance with early exit,
// one without, driven from the same request stream.
module tb_serial_mag_comparator_ctrl;

    localparam int unsigned W = 8;
    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;

    logic busy1, done1, gt1, eq1, lt1;
    logic busy0, done0, gt0, eq0, lt0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_mag_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .A_in(a_in), .B_in(b_in),
        .busy(busy1), .done(done1), .GT(gt1), .EQ(eq1), .LT(lt1)
    );

    serial_mag_comparator_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk(clk), .rst_n(rst_n), .start(start), .A_in(a_in), .B_in(b_in),
        .busy(busy0), .done(done0), .GT(gt0), .EQ(eq0), .LT(lt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request; both instances must finish with res, at lat1 / lat0 cycles after accept.
    // rep_cyc > 0 re-pulses start with different operands mid-scan.
    task automatic run_cmp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] res, input int lat1, input int lat0,
                           input int rep_cyc);
        int          seen1, seen0, cnt1, cnt0;
        logic [2:0]  prev0;
        seen1 = 0; seen0 = 0; cnt1 = 0; cnt0 = 0;
        prev0 = {gt0, eq0, lt0};
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_ee@E0"}, 32'(busy1), 32'd1);
        check({name, " busy_full@E0"}, 32'(busy0), 32'd1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1 && lat0 > 1)
                check({name, " hold_full"}, 32'({gt0, eq0, lt0}), 32'(prev0));
            if (done1) begin
                cnt1++;
                if (seen1 == 0) begin
                    seen1 = cyc;
                    check({name, " res_ee"}, 32'({gt1, eq1, lt1}), 32'(res));
                    check({name, " busy_ee@done"}, 32'(busy1), 32'd0);
                end
            end
            if (done0) begin
                cnt0++;
                if (seen0 == 0) begin
                    seen0 = cyc;
                    check({name, " res_full"}, 32'({gt0, eq0, lt0}), 32'(res));
                end
            end
            if (cyc == rep_cyc) begin
                start = 1'b1;
                a_in  = 8'hFF;
                b_in  = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        check({name, " lat_ee"}, 32'(seen1), 32'(lat1));
        check({name, " lat_full"}, 32'(seen0), 32'(lat0));
        check({name, " pulses_ee"}, 32'(cnt1), 32'd1);
        check({name, " pulses_full"}, 32'(cnt0), 32'd1);
        check({name, " res_held_ee"}, 32'({gt1, eq1, lt1}), 32'(res));
    endtask

    initial begin
        int dn;
        #12;
        check("reset_outs_ee", 32'({busy1, done1, gt1, eq1, lt1}), 32'd0);
        check("reset_outs_full", 32'({busy0, done0, gt0, eq0, lt0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_busy", 32'(busy1 | busy0), 32'd0);

        run_cmp("eq_a5",  8'hA5, 8'hA5, R_EQ, 8, 8, 0);
        run_cmp("msb_gt", 8'h80, 8'h7F, R_GT, 1, 8, 0);
        run_cmp("lsb_lt", 8'h12, 8'h13, R_LT, 8, 8, 0);
        run_cmp("bit6_gt", 8'h40, 8'h3F, R_GT, 2, 8, 0);
        run_cmp("busy_req", 8'h01, 8'h02, R_LT, 7, 8, 3);

        // abort mid-scan: outputs clear without a clock edge, no done pulse
        @(negedge clk);
        a_in  = 8'h12;
        b_in  = 8'h13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_abort_busy", 32'(busy1 & busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outs_ee", 32'({busy1, done1, gt1, eq1, lt1}), 32'd0);
        check("abort_outs_full", 32'({busy0, done0, gt0, eq0, lt0}), 32'd0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            dn += int'(done1) + int'(done0);
        end
        check("abort_no_done", 32'(dn), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_cmp("post_rst_eq", 8'h05, 8'h05, R_EQ, 8, 8, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
